// File: rtl/pa_ifu_btb_ctrl.sv
// BTB write-side controller: accepts branch-unit updates, picks the entry to write
// (tag hit first, round-robin victim otherwise) and sequences whole-table invalidates.
module pa_ifu_btb_ctrl #(
    parameter int ENTRY_NUM  = 16,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  cp0_ifu_btb_en,
    input  logic                  cp0_ifu_btb_inv,
    input  logic                  bju_btb_upd_vld,
    input  logic [ADDR_WIDTH-1:0] bju_btb_upd_tag,
    input  logic [ADDR_WIDTH-1:0] bju_btb_upd_tgt,
    output logic                  btb_upd_rdy,
    input  logic [ENTRY_NUM-1:0]  btb_entry_wr_hit,
    output logic [ADDR_WIDTH-1:0] btb_wr_acc_tag,
    output logic [ADDR_WIDTH-1:0] btb_upd_tag,
    output logic [ADDR_WIDTH-1:0] btb_upd_tgt,
    output logic [ENTRY_NUM-1:0]  btb_entry_upd,
    output logic [ENTRY_NUM-1:0]  btb_entry_updg,
    output logic [ENTRY_NUM-1:0]  btb_entry_clr,
    output logic [ENTRY_NUM-1:0]  btb_entry_clrg,
    output logic                  btb_inv_done
);

    localparam int                   PTR_W   = $clog2(ENTRY_NUM);
    localparam logic [PTR_W-1:0]     PTR_MAX = PTR_W'(ENTRY_NUM - 1);
    localparam logic [PTR_W-1:0]     PTR_ONE = PTR_W'(1);
    localparam logic [ENTRY_NUM-1:0] VEC_ONE = {{(ENTRY_NUM-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_UPD  = 2'd1,
        ST_INV  = 2'd2
    } state_t;

    state_t                r_state;
    logic [PTR_W-1:0]      r_vict_ptr;
    logic                  r_inv_pend;
    logic                  r_en_q;
    logic [ADDR_WIDTH-1:0] r_upd_tag;
    logic [ADDR_WIDTH-1:0] r_upd_tgt;

    logic                  w_inv_req;
    logic                  w_inv_any;
    logic                  w_upd_rdy;
    logic                  w_upd_acc;
    logic                  w_hit_any;
    logic [ENTRY_NUM-1:0]  w_hit_low;
    logic [ENTRY_NUM-1:0]  w_vict_vec;
    logic [ENTRY_NUM-1:0]  w_upd_vec;
    logic [ENTRY_NUM-1:0]  w_clr_vec;
    logic [PTR_W-1:0]      w_ptr_nxt;

    // Only a falling enable invalidates; re-enabling starts from whatever was cleared.
    assign w_inv_req = cp0_ifu_btb_inv | (r_en_q & ~cp0_ifu_btb_en);
    assign w_inv_any = r_inv_pend | w_inv_req;

    assign w_upd_rdy = (r_state == ST_IDLE) & ~w_inv_any;
    assign w_upd_acc = w_upd_rdy & bju_btb_upd_vld & cp0_ifu_btb_en;

    // Two's-complement trick isolates the lowest set bit of the hit vector.
    assign w_hit_any  = |btb_entry_wr_hit;
    assign w_hit_low  = btb_entry_wr_hit & (~btb_entry_wr_hit + VEC_ONE);
    assign w_vict_vec = VEC_ONE << r_vict_ptr;
    assign w_ptr_nxt  = (r_vict_ptr == PTR_MAX) ? '0 : r_vict_ptr + PTR_ONE;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        w_upd_vec = '0;
        w_clr_vec = '0;
        if (r_state == ST_UPD) begin
            w_upd_vec = w_hit_any ? w_hit_low : w_vict_vec;
        end
        if (r_state == ST_INV) begin
            w_clr_vec = '1;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register
        // samples pre-edge values regardless of statement order.
        if (!cpurst_b) begin
            r_state    <= ST_IDLE;
            r_vict_ptr <= '0;
            r_inv_pend <= 1'b0;
            r_en_q     <= 1'b0;
            r_upd_tag  <= '0;
            r_upd_tgt  <= '0;
        end else begin
            r_en_q <= cp0_ifu_btb_en;
            case (r_state)
                ST_IDLE: begin
                    if (w_inv_any) begin
                        r_inv_pend <= 1'b1;
                        r_state    <= ST_INV;
                    end else if (w_upd_acc) begin
                        r_upd_tag <= bju_btb_upd_tag;
                        r_upd_tgt <= bju_btb_upd_tgt;
                        r_state   <= ST_UPD;
                    end
                end
                ST_UPD: begin
                    r_inv_pend <= w_inv_any;
                    if (!w_hit_any) begin
                        r_vict_ptr <= w_ptr_nxt;
                    end
                    r_state <= ST_IDLE;
                end
                ST_INV: begin
                    // A request landing in the clearing cycle must survive for one more pass.
                    r_inv_pend <= w_inv_req;
                    r_vict_ptr <= '0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign btb_upd_rdy    = w_upd_rdy;
    assign btb_upd_tag    = r_upd_tag;
    assign btb_upd_tgt    = r_upd_tgt;
    assign btb_wr_acc_tag = r_upd_tag;
    assign btb_entry_upd  = w_upd_vec;
    assign btb_entry_updg = w_upd_vec;
    assign btb_entry_clr  = w_clr_vec;
    assign btb_entry_clrg = w_clr_vec;
    assign btb_inv_done   = (r_state == ST_INV);

endmodule

// File: tb/tb_pa_ifu_btb_ctrl.sv
// Directed bench for pa_ifu_btb_ctrl: a scoreboard holds the expected update strobe,
// tag and target; a negedge monitor pops and compares whenever a strobe appears.
module tb_pa_ifu_btb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        inv;
    logic        upd_vld;
    logic [15:0] upd_tag_in;
    logic [15:0] upd_tgt_in;
    logic        upd_rdy;
    logic [15:0] wr_hit;
    logic [15:0] wr_acc_tag;
    logic [15:0] upd_tag;
    logic [15:0] upd_tgt;
    logic [15:0] entry_upd;
    logic [15:0] entry_updg;
    logic [15:0] entry_clr;
    logic [15:0] entry_clrg;
    logic        inv_done;

    typedef struct {
        logic [15:0] strobe;
        logic [15:0] tag;
        logic [15:0] tgt;
    } exp_t;

    exp_t q_exp[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   m_ptr    = 0;
    bit   mon_en   = 0;

    pa_ifu_btb_ctrl #(.ENTRY_NUM(16), .ADDR_WIDTH(16)) dut (
        .forever_cpuclk   (clk),
        .cpurst_b         (rst_n),
        .cp0_ifu_btb_en   (en),
        .cp0_ifu_btb_inv  (inv),
        .bju_btb_upd_vld  (upd_vld),
        .bju_btb_upd_tag  (upd_tag_in),
        .bju_btb_upd_tgt  (upd_tgt_in),
        .btb_upd_rdy      (upd_rdy),
        .btb_entry_wr_hit (wr_hit),
        .btb_wr_acc_tag   (wr_acc_tag),
        .btb_upd_tag      (upd_tag),
        .btb_upd_tgt      (upd_tgt),
        .btb_entry_upd    (entry_upd),
        .btb_entry_updg   (entry_updg),
        .btb_entry_clr    (entry_clr),
        .btb_entry_clrg   (entry_clrg),
        .btb_inv_done     (inv_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Victim model: index of the next entry to replace on a miss.
    function automatic logic [15:0] miss_strobe();
        logic [15:0] v;
        v = 16'h0001 << m_ptr;
        m_ptr = (m_ptr + 1) % 16;
        return v;
    endfunction

    function automatic logic [15:0] lowest_hit(input logic [15:0] hit);
        logic [15:0] v;
        v = '0;
        for (int i = 15; i >= 0; i--) begin
            if (hit[i]) v = 16'h0001 << i;
        end
        return v;
    endfunction

    // Called just after a rising edge; returns just after the edge that ends UPD.
    task automatic do_update(input logic [15:0] tag, input logic [15:0] tgt,
                             input logic [15:0] hit, input bit drop_en);
        exp_t e;
        upd_vld    = 1'b1;
        upd_tag_in = tag;
        upd_tgt_in = tgt;
        wr_hit     = '0;
        @(negedge clk);
        check("rdy_idle", upd_rdy, 1);
        tick();
        upd_vld = 1'b0;
        wr_hit  = hit;
        if (drop_en) en = 1'b0;
        e.strobe = (hit != 0) ? lowest_hit(hit) : miss_strobe();
        e.tag    = tag;
        e.tgt    = tgt;
        q_exp.push_back(e);
        @(negedge clk);
        check("rdy_in_upd", upd_rdy, 0);
        check("wr_acc_tag", wr_acc_tag, tag);
        tick();
        wr_hit = '0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            check("updg_eq_upd", entry_updg, entry_upd);
            check("clrg_eq_clr", entry_clrg, entry_clr);
            check("upd_clr_overlap", entry_upd & entry_clr, 0);
            if (entry_upd !== 16'h0000) begin
                check("upd_expected", q_exp.size() != 0, 1);
                if (q_exp.size() != 0) begin
                    e = q_exp.pop_front();
                    check("upd_strobe", entry_upd, e.strobe);
                    check("upd_tag", upd_tag, e.tag);
                    check("upd_tgt", upd_tgt, e.tgt);
                end
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        inv        = 1'b0;
        upd_vld    = 1'b0;
        upd_tag_in = '0;
        upd_tgt_in = '0;
        wr_hit     = '0;
        mon_en     = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_rdy", upd_rdy, 1);
        check("rst_upd", entry_upd, 0);
        check("rst_clr", entry_clr, 0);
        check("rst_done", inv_done, 0);
        check("rst_tag", upd_tag, 0);
        check("rst_tgt", upd_tgt, 0);
        check("rst_acc_tag", wr_acc_tag, 0);
        #2 rst_n = 1'b1;
        tick();
        en = 1'b1;
        tick();
        check("en_rise_no_inv", inv_done, 0);

        // First miss lands on entry 0, then a hit picks the lowest hit entry
        do_update(16'h1234, 16'h5678, 16'h0000, 1'b0);
        do_update(16'h00AA, 16'h0BBB, 16'h0024, 1'b0);

        // Seventeen misses walk the victim pointer through a wrap
        for (int i = 0; i < 17; i++) begin
            do_update(16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h0000, 1'b0);
        end

        // Invalidate wins over a coincident update, which is then taken next
        inv        = 1'b1;
        upd_vld    = 1'b1;
        upd_tag_in = 16'h4444;
        upd_tgt_in = 16'h4545;
        @(negedge clk);
        check("inv_prio_rdy", upd_rdy, 0);
        tick();
        inv = 1'b0;
        @(negedge clk);
        check("inv_clr", entry_clr, 16'hFFFF);
        check("inv_done", inv_done, 1);
        check("inv_rdy", upd_rdy, 0);
        m_ptr = 0;
        tick();
        @(negedge clk);
        check("post_inv_rdy", upd_rdy, 1);
        check("post_inv_done", inv_done, 0);
        check("post_inv_clr", entry_clr, 0);
        tick();
        upd_vld = 1'b0;
        q_exp.push_back('{16'h0001, 16'h4444, 16'h4545});
        m_ptr = 1;
        @(negedge clk);
        check("post_inv_upd_tag", wr_acc_tag, 16'h4444);
        tick();

        // Enable falls during UPD: update finishes, then exactly one invalidate
        do_update(16'h5555, 16'h5656, 16'h0000, 1'b1);
        @(negedge clk);
        check("en_fall_rdy", upd_rdy, 0);
        check("en_fall_clr0", entry_clr, 0);
        tick();
        @(negedge clk);
        check("en_fall_clr", entry_clr, 16'hFFFF);
        check("en_fall_done", inv_done, 1);
        m_ptr = 0;
        tick();
        @(negedge clk);
        check("en_fall_idle_rdy", upd_rdy, 1);
        check("en_fall_done_end", inv_done, 0);

        // Update while disabled is consumed and dropped
        tick();
        upd_vld    = 1'b1;
        upd_tag_in = 16'h6666;
        upd_tgt_in = 16'h6767;
        @(negedge clk);
        check("dis_rdy", upd_rdy, 1);
        tick();
        upd_vld = 1'b0;
        @(negedge clk);
        check("dis_stay_idle", upd_rdy, 1);
        check("dis_keeps_tag", upd_tag, 16'h5555);
        tick();
        en = 1'b1;
        @(negedge clk);
        check("en_rise_rdy", upd_rdy, 1);
        tick();
        @(negedge clk);
        check("en_rise_clr", entry_clr, 0);
        check("en_rise_done", inv_done, 0);
        tick();
        do_update(16'h0101, 16'h0202, 16'h0000, 1'b0);

        // Invalidate during INV forces one more INV
        inv = 1'b1;
        @(negedge clk);
        check("inv2_rdy", upd_rdy, 0);
        tick();
        @(negedge clk);
        check("inv2_first_done", inv_done, 1);
        tick();
        inv = 1'b0;
        @(negedge clk);
        check("inv2_pend_rdy", upd_rdy, 0);
        check("inv2_gap_done", inv_done, 0);
        tick();
        @(negedge clk);
        check("inv2_second_done", inv_done, 1);
        check("inv2_second_clr", entry_clr, 16'hFFFF);
        m_ptr = 0;
        tick();
        @(negedge clk);
        check("inv2_end_rdy", upd_rdy, 1);
        check("inv2_end_done", inv_done, 0);
        tick();

        // Reset in the UPD cycle aborts with no strobe
        do_update(16'h0C0C, 16'h0D0D, 16'h0000, 1'b0);
        upd_vld    = 1'b1;
        upd_tag_in = 16'h7777;
        upd_tgt_in = 16'h7878;
        @(negedge clk);
        check("rst_mid_hs_rdy", upd_rdy, 1);
        tick();
        upd_vld = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        check("rst_mid_upd", entry_upd, 0);
        check("rst_mid_tag", upd_tag, 0);
        check("rst_mid_tgt", upd_tgt, 0);
        check("rst_mid_clr", entry_clr, 0);
        check("rst_mid_done", inv_done, 0);
        check("rst_mid_rdy", upd_rdy, 1);
        m_ptr = 0;
        tick();
        rst_n = 1'b1;
        tick();
        do_update(16'h0A0A, 16'h0B0B, 16'h0000, 1'b0);

        tick();
        tick();
        mon_en = 1'b0;
        check("scoreboard_empty", q_exp.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
